// File: rtl/tile_mover.sv
// tile_mover: moves one sprite across a tile map once per frame at sub-pixel speed.
// Buffers a requested turn, checks walls through a map-read handshake, and wraps x through the tunnel.
module tile_mover #(
  parameter int unsigned TILE_SIZE = 8,
  parameter int unsigned MAP_COLS  = 32,
  parameter int unsigned MAP_ROWS  = 36,
  parameter int unsigned TILE_W    = 4,
  parameter int unsigned POS_W     = 9,
  parameter int unsigned SPEED_W   = 8,
  parameter int unsigned START_X   = 8,
  parameter int unsigned START_Y   = 32,
  parameter int unsigned START_DIR = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 frame_stb,
  input  logic                                 enable,
  input  logic [SPEED_W:0]                     speed,
  input  logic [1:0]                           dir_req,
  input  logic                                 dir_req_valid,
  output logic                                 map_req,
  output logic [$clog2(MAP_COLS*MAP_ROWS)-1:0] map_addr,
  input  logic                                 map_ack,
  input  logic [TILE_W-1:0]                    map_data,
  output logic [POS_W-1:0]                     x_pos,
  output logic [POS_W-1:0]                     y_pos,
  output logic [1:0]                           dir,
  output logic                                 moving,
  output logic                                 busy,
  output logic                                 wall_hit,
  output logic                                 frame_overrun
);

  localparam int unsigned ADDR_W = $clog2(MAP_COLS*MAP_ROWS);
  localparam int unsigned SH     = $clog2(TILE_SIZE);
  localparam int unsigned X_MAX  = MAP_COLS*TILE_SIZE - 1;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_RIGHT = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_DOWN  = 2'd3;

  localparam logic [SPEED_W:0] SPD_ONE = {1'b1, {SPEED_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, TURN_REQ, FWD_REQ, MOVE} state_t;

  state_t              state, state_d;
  logic [POS_W-1:0]    x_d, y_d;
  logic [1:0]          dir_d, pending;
  logic [SPEED_W-1:0]  acc, acc_d;
  logic [SPEED_W:0]    spd_sat, acc_sum;
  logic                moving_d, map_req_d, wall_hit_d, overrun_d, go;
  logic [ADDR_W-1:0]   map_addr_d;
  logic                xa, ya, pend_aligned;
  logic                pend_ok, dir_ok;
  logic [ADDR_W-1:0]   pend_addr, dir_addr;

  // Neighbouring tile in direction d; MSB clear when the row is off the map.
  function automatic logic [ADDR_W:0] target(input logic [1:0] d,
                                             input logic [POS_W-1:0] x,
                                             input logic [POS_W-1:0] y);
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] row;
    logic             ok;
    col = x >> SH;
    row = y >> SH;
    ok  = 1'b1;
    case (d)
      D_UP: begin
        ok  = (y != '0);
        row = (y - POS_W'(1)) >> SH;
      end
      D_DOWN:  row = row + POS_W'(1);
      D_RIGHT: col = (col == POS_W'(MAP_COLS-1)) ? '0 : col + POS_W'(1);
      default: col = (x == '0) ? POS_W'(MAP_COLS-1) : (x - POS_W'(1)) >> SH;
    endcase
    if (row >= POS_W'(MAP_ROWS)) ok = 1'b0;
    return {ok, ADDR_W'(ADDR_W'(row) * ADDR_W'(MAP_COLS) + ADDR_W'(col))};
  endfunction

  assign xa = (x_pos[SH-1:0] == '0);
  assign ya = (y_pos[SH-1:0] == '0);
  assign pend_aligned = (pending == D_UP || pending == D_DOWN) ? xa : ya;
  assign {pend_ok, pend_addr} = target(pending, x_pos, y_pos);
  assign {dir_ok, dir_addr}   = target(dir, x_pos, y_pos);

  assign spd_sat = (speed > SPD_ONE) ? SPD_ONE : speed;
  assign acc_sum = {1'b0, acc} + spd_sat;
  assign go      = frame_stb && enable;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state;
    x_d        = x_pos;
    y_d        = y_pos;
    dir_d      = dir;
    acc_d      = acc;
    moving_d   = moving;
    map_req_d  = map_req;
    map_addr_d = map_addr;
    wall_hit_d = 1'b0;
    overrun_d  = go && (state != IDLE);

    case (state)
      IDLE: begin
        if (go) begin
          acc_d = acc_sum[SPEED_W-1:0];
          if (acc_sum[SPEED_W]) begin
            if (pending == dir) begin
              state_d = FWD_REQ;
              if (dir_ok) begin
                map_req_d  = 1'b1;
                map_addr_d = dir_addr;
              end
            end else if (pending == ~dir) begin
              // Reversal never needs alignment or a turn lookup.
              dir_d   = pending;
              state_d = FWD_REQ;
              if (pend_ok) begin
                map_req_d  = 1'b1;
                map_addr_d = pend_addr;
              end
            end else begin
              state_d = TURN_REQ;
              if (pend_ok && pend_aligned) begin
                map_req_d  = 1'b1;
                map_addr_d = pend_addr;
              end
            end
          end
        end
      end
      TURN_REQ: begin
        // No read was issued when misaligned or off-map: fall straight through.
        if (!map_req || map_ack) begin
          if (map_req && map_data == '0) begin
            dir_d     = pending;
            state_d   = MOVE;
            map_req_d = 1'b0;
          end else begin
            state_d   = FWD_REQ;
            map_req_d = dir_ok;
            if (dir_ok) map_addr_d = dir_addr;
          end
        end
      end
      FWD_REQ: begin
        if (!map_req || map_ack) begin
          map_req_d = 1'b0;
          if (map_req && map_data == '0) begin
            state_d = MOVE;
          end else begin
            state_d    = IDLE;
            wall_hit_d = 1'b1;
            moving_d   = 1'b0;
          end
        end
      end
      MOVE: begin
        state_d  = IDLE;
        moving_d = 1'b1;
        case (dir)
          D_UP:    y_d = y_pos - POS_W'(1);
          D_DOWN:  y_d = y_pos + POS_W'(1);
          D_RIGHT: x_d = (x_pos == POS_W'(X_MAX)) ? '0 : x_pos + POS_W'(1);
          default: x_d = (x_pos == '0) ? POS_W'(X_MAX) : x_pos - POS_W'(1);
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      x_pos         <= POS_W'(START_X);
      y_pos         <= POS_W'(START_Y);
      dir           <= 2'(START_DIR);
      pending       <= 2'(START_DIR);
      acc           <= '0;
      moving        <= 1'b0;
      map_req       <= 1'b0;
      map_addr      <= '0;
      busy          <= 1'b0;
      wall_hit      <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state         <= state_d;
      x_pos         <= x_d;
      y_pos         <= y_d;
      dir           <= dir_d;
      acc           <= acc_d;
      moving        <= moving_d;
      map_req       <= map_req_d;
      map_addr      <= map_addr_d;
      busy          <= (state_d != IDLE);
      wall_hit      <= wall_hit_d;
      frame_overrun <= overrun_d;
      if (dir_req_valid) pending <= dir_req;
    end
  end

endmodule

// File: tb/tb_tile_mover.sv
// Bench for tile_mover: map responder with programmable ack delay plus a
// frame-level movement model derived from the tile rules.
module tb_tile_mover;

  localparam int T    = 8;
  localparam int COLS = 32;
  localparam int ROWS = 36;
  localparam int XW   = COLS*T;
  localparam int AW   = $clog2(COLS*ROWS);

  logic          clk, rst_n, frame_stb, enable, dir_req_valid;
  logic [8:0]    speed;
  logic [1:0]    dir_req, dir;
  logic          map_req, map_ack, moving, busy, wall_hit, frame_overrun;
  logic [AW-1:0] map_addr;
  logic [3:0]    map_data;
  logic [8:0]    x_pos, y_pos;

  int checks = 0;
  int errors = 0;

  logic [3:0] tile_map [COLS*ROWS];
  int  ack_delay;
  bit  spurious;

  int m_x, m_y, m_dir, m_pend, m_acc, m_moving;

  tile_mover dut (
    .clk(clk), .rst_n(rst_n), .frame_stb(frame_stb), .enable(enable),
    .speed(speed), .dir_req(dir_req), .dir_req_valid(dir_req_valid),
    .map_req(map_req), .map_addr(map_addr), .map_ack(map_ack), .map_data(map_data),
    .x_pos(x_pos), .y_pos(y_pos), .dir(dir), .moving(moving), .busy(busy),
    .wall_hit(wall_hit), .frame_overrun(frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map ROM responder; also watches that a pending read keeps its address.
  initial begin : responder
    bit in_read;
    int wait_cnt;
    logic [AW-1:0] rd_addr;
    in_read = 0;
    wait_cnt = 0;
    rd_addr = '0;
    map_ack = 1'b0;
    map_data = '0;
    forever begin
      @(posedge clk); #1;
      map_ack = 1'b0;
      if (rst_n && map_req) begin
        if (!in_read) begin
          in_read = 1;
          wait_cnt = 0;
          rd_addr = map_addr;
        end else begin
          checks++;
          if (map_addr !== rd_addr) begin
            errors++;
            $display("FAIL addr_stable: map_addr=%0d held_for=%0d", map_addr, rd_addr);
          end
        end
        if (wait_cnt >= ack_delay) begin
          map_ack = 1'b1;
          map_data = tile_map[map_addr];
          in_read = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        in_read = 0;
        if (spurious) begin
          map_ack = 1'b1;
          map_data = 4'hF;
        end
      end
    end
  end

  function automatic bit tile_open(input int d, input int x, input int y);
    int col, row;
    case (d)
      0: begin
        if (y == 0) return 0;
        col = x / T;
        row = (y - 1) / T;
      end
      3: begin col = x / T; row = y / T + 1; end
      1: begin col = (x / T + 1) % COLS; row = y / T; end
      default: begin col = ((x + XW - 1) % XW) / T; row = y / T; end
    endcase
    if (row >= ROWS) return 0;
    return tile_map[row*COLS + col] == 4'd0;
  endfunction

  function automatic bit turn_aligned(input int d);
    if (d == 0 || d == 3) return (m_x % T) == 0;
    return (m_y % T) == 0;
  endfunction

  // One frame of the reference behaviour; returns the expected wall_hit pulses.
  task automatic model_frame(output int exp_wall);
    int sum;
    bit turned;
    exp_wall = 0;
    if (!enable) return;
    sum = m_acc + ((speed > 9'd256) ? 256 : int'(speed));
    if (sum < 256) begin
      m_acc = sum;
      return;
    end
    m_acc = sum - 256;
    turned = 0;
    if (m_pend != m_dir) begin
      if (m_pend == 3 - m_dir) m_dir = m_pend;
      else if (turn_aligned(m_pend) && tile_open(m_pend, m_x, m_y)) begin
        m_dir = m_pend;
        turned = 1;
      end
    end
    if (turned || tile_open(m_dir, m_x, m_y)) begin
      case (m_dir)
        0: m_y = m_y - 1;
        3: m_y = m_y + 1;
        1: m_x = (m_x + 1) % XW;
        default: m_x = (m_x + XW - 1) % XW;
      endcase
      m_moving = 1;
    end else begin
      m_moving = 0;
      exp_wall = 1;
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < COLS*ROWS; i++) tile_map[i] = 4'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_stb = 1'b0;
    enable = 1'b1;
    dir_req_valid = 1'b0;
    dir_req = 2'd0;
    speed = 9'd256;
    ack_delay = 0;
    spurious = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_x = 8; m_y = 32; m_dir = 1; m_pend = 1; m_acc = 0; m_moving = 0;
    @(posedge clk); #1;
  endtask

  task automatic set_dir_req(input int d);
    dir_req = 2'(d);
    dir_req_valid = 1'b1;
    @(posedge clk); #1;
    dir_req_valid = 1'b0;
    m_pend = d;
  endtask

  // Pulse one frame, wait for the operation to finish, compare with the model.
  task automatic run_frame(input int exp_addr, output int lat);
    int exp_wall, walls, n;
    model_frame(exp_wall);
    frame_stb = 1'b1;
    @(posedge clk); #1;
    frame_stb = 1'b0;
    if (exp_addr >= 0) begin
      checks++;
      if (map_req !== 1'b1 || map_addr !== AW'(exp_addr)) begin
        errors++;
        $display("FAIL first_read: map_req=%0b map_addr=%0d expected req=1 addr=%0d",
                 map_req, map_addr, exp_addr);
      end
    end
    walls = int'(wall_hit === 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      walls += int'(wall_hit === 1'b1);
    end
    lat = n;
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL busy_timeout: busy still high after %0d cycles", n);
    end
    @(posedge clk); #1;
    walls += int'(wall_hit === 1'b1);
    checks++;
    if (x_pos !== 9'(m_x) || y_pos !== 9'(m_y)) begin
      errors++;
      $display("FAIL position: got (%0d,%0d) expected (%0d,%0d)", x_pos, y_pos, m_x, m_y);
    end
    checks++;
    if (dir !== 2'(m_dir)) begin
      errors++;
      $display("FAIL direction: got %0d expected %0d", dir, m_dir);
    end
    checks++;
    if (moving !== 1'(m_moving)) begin
      errors++;
      $display("FAIL moving: got %0b expected %0d", moving, m_moving);
    end
    checks++;
    if (walls != exp_wall) begin
      errors++;
      $display("FAIL wall_hit_count: got %0d pulses expected %0d", walls, exp_wall);
    end
    checks++;
    if (busy !== 1'b0 || frame_overrun !== 1'b0) begin
      errors++;
      $display("FAIL idle_flags: busy=%0b frame_overrun=%0b expected 0,0", busy, frame_overrun);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (x_pos !== 9'd8 || y_pos !== 9'd32 || dir !== 2'd1) begin
      errors++;
      $display("FAIL reset_pos: x=%0d y=%0d dir=%0d expected 8,32,1", x_pos, y_pos, dir);
    end
    checks++;
    if (map_req !== 1'b0 || map_addr !== '0 || moving !== 1'b0) begin
      errors++;
      $display("FAIL reset_map: req=%0b addr=%0d moving=%0b expected 0,0,0", map_req, map_addr, moving);
    end
    checks++;
    if (busy !== 1'b0 || wall_hit !== 1'b0 || frame_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%0b wall=%0b ovr=%0b expected 0,0,0", busy, wall_hit, frame_overrun);
    end
  endtask

  task automatic test_corridor();
    int lat;
    do_reset();
    clear_map();
    run_frame(4*32 + 2, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL straight_latency: got %0d busy cycles expected 2", lat);
    end
    repeat (5) run_frame(-1, lat);
    checks++;
    if (x_pos !== 9'd14) begin
      errors++;
      $display("FAIL corridor_x: got %0d expected 14", x_pos);
    end
  endtask

  task automatic test_half_speed();
    int lat;
    do_reset();
    clear_map();
    speed = 9'd128;
    repeat (6) run_frame(-1, lat);
    checks++;
    if (x_pos !== 9'd11) begin
      errors++;
      $display("FAIL half_speed_x: got %0d expected 11", x_pos);
    end
    speed = 9'd511;
    repeat (4) run_frame(-1, lat);
    checks++;
    if (x_pos !== 9'd15) begin
      errors++;
      $display("FAIL saturated_speed_x: got %0d expected 15", x_pos);
    end
  endtask

  task automatic test_turn();
    int lat;
    do_reset();
    clear_map();
    repeat (5) run_frame(-1, lat);
    set_dir_req(0);
    repeat (3) run_frame(-1, lat);
    checks++;
    if (x_pos !== 9'd16 || dir !== 2'd1) begin
      errors++;
      $display("FAIL turn_deferred: x=%0d dir=%0d expected 16,1", x_pos, dir);
    end
    run_frame(3*32 + 2, lat);
    checks++;
    if (dir !== 2'd0 || y_pos !== 9'd31 || x_pos !== 9'd16 || lat != 2) begin
      errors++;
      $display("FAIL turn_taken: dir=%0d x=%0d y=%0d lat=%0d expected 0,16,31,2", dir, x_pos, y_pos, lat);
    end
    // Reversal mid-tile
    do_reset();
    repeat (5) run_frame(-1, lat);
    set_dir_req(2);
    run_frame(4*32 + 1, lat);
    checks++;
    if (dir !== 2'd2 || x_pos !== 9'd12 || lat != 2) begin
      errors++;
      $display("FAIL reversal: dir=%0d x=%0d lat=%0d expected 2,12,2", dir, x_pos, lat);
    end
  endtask

  task automatic test_wall();
    int lat;
    do_reset();
    clear_map();
    tile_map[4*32 + 3] = 4'd1;
    repeat (8) run_frame(-1, lat);
    repeat (3) run_frame(-1, lat);
    checks++;
    if (x_pos !== 9'd16 || moving !== 1'b0) begin
      errors++;
      $display("FAIL wall_stop: x=%0d moving=%0b expected 16,0", x_pos, moving);
    end
  endtask

  task automatic test_tunnel();
    int lat, ew, n;
    do_reset();
    clear_map();
    n = 0;
    while (m_x != 255 && n < 400) begin
      run_frame(-1, lat);
      n++;
    end
    ack_delay = 3;
    model_frame(ew);
    frame_stb = 1'b1;
    @(posedge clk); #1;
    frame_stb = 1'b0;
    checks++;
    if (map_req !== 1'b1 || map_addr !== AW'(4*32)) begin
      errors++;
      $display("FAIL tunnel_read: req=%0b addr=%0d expected 1,128", map_req, map_addr);
    end
    frame_stb = 1'b1;
    @(posedge clk); #1;
    frame_stb = 1'b0;
    checks++;
    if (frame_overrun !== 1'b1 || map_req !== 1'b1 || map_addr !== AW'(4*32)) begin
      errors++;
      $display("FAIL overrun: ovr=%0b req=%0b addr=%0d expected 1,1,128", frame_overrun, map_req, map_addr);
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (x_pos !== 9'd0 || x_pos !== 9'(m_x) || y_pos !== 9'd32 || frame_overrun !== 1'b0) begin
      errors++;
      $display("FAIL tunnel_wrap: x=%0d y=%0d ovr=%0b expected 0,32,0", x_pos, y_pos, frame_overrun);
    end
    ack_delay = 0;
    run_frame(-1, lat);
  endtask

  task automatic test_random();
    int lat;
    do_reset();
    for (int i = 0; i < COLS*ROWS; i++) tile_map[i] = ($urandom_range(0, 99) < 20) ? 4'($urandom_range(1, 15)) : 4'd0;
    tile_map[4*32 + 1] = 4'd0;
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 9) < 3) set_dir_req(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) speed = 9'($urandom_range(0, 511));
      enable = ($urandom_range(0, 9) != 0);
      ack_delay = int'($urandom_range(0, 2));
      spurious = bit'($urandom_range(0, 1));
      run_frame(-1, lat);
    end
    enable = 1'b1;
    spurious = 0;
    ack_delay = 0;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    clear_map();
    ack_delay = 10;
    frame_stb = 1'b1;
    @(posedge clk); #1;
    frame_stb = 1'b0;
    checks++;
    if (map_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_read_setup: map_req=%0b expected 1", map_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (map_req !== 1'b0 || busy !== 1'b0 || map_addr !== '0) begin
      errors++;
      $display("FAIL async_reset: req=%0b busy=%0b addr=%0d expected 0,0,0", map_req, busy, map_addr);
    end
    checks++;
    if (x_pos !== 9'd8 || y_pos !== 9'd32 || dir !== 2'd1 || moving !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_pos: x=%0d y=%0d dir=%0d moving=%0b expected 8,32,1,0", x_pos, y_pos, dir, moving);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_delay = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    frame_stb = 1'b0;
    enable = 1'b1;
    speed = 9'd256;
    dir_req = 2'd0;
    dir_req_valid = 1'b0;
    ack_delay = 0;
    spurious = 0;
    clear_map();
    test_reset();
    test_corridor();
    test_half_speed();
    test_turn();
    test_wall();
    test_tunnel();
    test_random();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_mover.md
# tile_mover

Parametrised tile-grid actor movement engine: advances one sprite (Pac-Man or a ghost) across a tile map once per frame tick at a programmable sub-pixel speed. It buffers a requested turn, checks walls through a shared map-read handshake, and supports horizontal tunnel wrap-around. It sits between the input/AI logic and the sprite renderer, one instance per actor, with several instances arbitrated onto one map ROM port.

## Interface

Parameters:
- TILE_SIZE, 8: pixels per tile edge; power of two, ≥ 2.
- MAP_COLS, 32: tiles per row.
- MAP_ROWS, 36: tile rows.
- TILE_W, 4: map entry width; a nonzero entry is a wall.
- POS_W, 9: width of x/y pixel coordinates.
- SPEED_W, 8: fractional bits of the speed accumulator.
- START_X, 8 / START_Y, 32: reset position in pixels.
- START_DIR, 1: reset direction; encoding 0 UP, 1 RIGHT, 2 LEFT, 3 DOWN.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_stb  in  1  one-cycle pulse per frame.
- enable  in  1  when low, frame_stb is ignored.
- speed  in  SPEED_W+1  pixels/frame × 2^SPEED_W; values above 2^SPEED_W saturate to 2^SPEED_W (1 px/frame).
- dir_req  in  2  requested direction.
- dir_req_valid  in  1  latches dir_req into the pending register.
- map_req  out  1  map read request.
- map_addr  out  $clog2(MAP_COLS*MAP_ROWS)  row*MAP_COLS + col.
- map_ack  in  1  read completes; map_data is valid this cycle.
- map_data  in  TILE_W  tile value.
- x_pos / y_pos  out  POS_W  sprite top-left, in pixels.
- dir  out  2  current direction.
- moving  out  1  high after a successful step; low after wall contact.
- busy  out  1  FSM not in IDLE.
- wall_hit  out  1  one-cycle pulse when a forward step is blocked.
- frame_overrun  out  1  one-cycle pulse when frame_stb arrives while busy.

## Operation

- Pending register: `pending <= dir_req` on any cycle with `dir_req_valid`. It is held until overwritten. Reset value is START_DIR.
- FSM states: IDLE, TURN_REQ, FWD_REQ, MOVE.
- IDLE, on `frame_stb && enable`:
  - Compute `acc + sat(speed)`.
  - If the sum ≥ 2^SPEED_W: subtract 2^SPEED_W, store, and go to TURN_REQ if `pending != dir`, else FWD_REQ.
  - Otherwise: store the sum and stay in IDLE.
- Alignment: `xa = x mod TILE_SIZE == 0`, `ya = y mod TILE_SIZE == 0`.
- Turn legality:
  - UP/DOWN require xa; LEFT/RIGHT require ya.
  - A reversal (opposite of dir) requires no alignment and no lookup; it is adopted immediately and the FSM goes to FWD_REQ.
- Target tile for direction d (col = x/T, row = y/T):
  - UP: (x/T, (y−1)/T)
  - DOWN: (x/T, y/T+1)
  - RIGHT: (x/T+1, y/T)
  - LEFT: ((x−1)/T, y/T)
  - Columns wrap modulo MAP_COLS; x−1 at x = 0 uses col MAP_COLS−1.
  - A row <0 or ≥ MAP_ROWS is a wall with no map read.
- TURN_REQ:
  - If alignment fails, go to FWD_REQ with no read.
  - Otherwise read the pending target. Open: `dir <= pending`, go to MOVE. Wall: go to FWD_REQ.
- FWD_REQ: read the target for dir.
  - Open: go to MOVE.
  - Wall: pulse wall_hit, `moving <= 0`, go to IDLE.
- MOVE: step one pixel in dir, set `moving <= 1`, go to IDLE.
  - x wraps: RIGHT at MAP_COLS*T−1 goes to 0; LEFT at 0 goes to MAP_COLS*T−1.
  - y never wraps.
- Handshake:
  - map_req and map_addr are registered on entry to a read state.
  - Both are held stable until the cycle map_ack is sampled high.
  - map_req drops on the following edge unless the next state issues a new read.
  - map_ack with map_req low is ignored.
- frame_stb while busy: the frame is dropped (acc unchanged) and frame_overrun pulses.
- enable low: frames are ignored; an operation already in flight completes.
- Reset values: x_pos = START_X, y_pos = START_Y, dir = START_DIR, pending = START_DIR, acc = 0, state IDLE, and map_req, map_addr, moving, busy, wall_hit, frame_overrun all 0.
- Reset asserted mid-read drops map_req asynchronously.

## Timing

- Zero-wait ack (ack in first req cycle), frame_stb in cycle 0:
  - Straight step: FWD_REQ in cycle 1, MOVE in cycle 2, new x/y visible in cycle 3.
  - Turn attempt: TURN_REQ in cycle 1. If open, MOVE in cycle 2, x/y in cycle 3. If blocked, FWD_REQ in cycle 2, x/y in cycle 4.
- Each ack wait-cycle adds one cycle.
- wall_hit is high in the cycle after the blocking ack.
- busy is high exactly while state ≠ IDLE.
- Maximum steps per frame: 1.

## Test plan

- Straight corridor: speed = 256, dir RIGHT, open tiles, from x = 8 → x increments by 1 per frame_stb. map_addr = 4*32+2 on the first frame.
- Half speed: speed = 128 → steps occur on every second frame. acc alternates 128/0. With speed = 511, behaviour is identical to speed = 256.
- Buffered turn: pending UP issued at x = 13 with an open tile above column 2 → no turn at x = 13..15. At x = 16 TURN_REQ reads (col 2, row 3) and dir becomes UP. Reversal LEFT at x = 13 is taken on the next step with no TURN_REQ read.
- Wall: RIGHT with tile (col 3, row 4) = 1 at x = 16 → wall_hit pulses once, x stays 16, moving = 0; the same result repeats on every frame.
- Tunnel wrap and handshake: x = 255 RIGHT with ack delayed 3 cycles → map_addr stays row*32+0 and stable throughout. x becomes 0. A frame_stb during the wait pulses frame_overrun.
- Reset mid-read: deassert rst_n while map_req = 1 → map_req = 0 immediately; all outputs return to their reset values.
